// File: rtl/scv_pkg.sv
// Shared types and CRC-32 helpers for the video capture block.
// The CRC is the reflected form (poly 0xEDB88320), as used by zip/ethernet.
package scv_pkg;

   typedef enum logic [1:0] {
      VCAP_IDLE,
      VCAP_WAIT_VS,
      VCAP_CAPTURE
   } vcap_state_t;

   localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
      logic [31:0] c;
      c = crc ^ {24'd0, b};
      for (int i = 0; i < 8; i++)
         c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
      return c;
   endfunction

endpackage

// File: rtl/video_capture_crc.sv
// Combinational next-CRC over one DW-bit pixel, bytes folded in MSB first.
module crc32_par
   import scv_pkg::*;
#(
   parameter int DW = 24
) (
   input  logic [31:0]   crc_in,
   input  logic [DW-1:0] data,
   output logic [31:0]   crc_out
);

   localparam int NB = DW / 8;

   logic [NB:0][31:0] chain;

   assign chain[0] = crc_in;

   for (genvar b = 0; b < NB; b++) begin : g_byte
      assign chain[b+1] = crc32_byte(chain[b], data[DW-1-8*b -: 8]);
   end

   assign crc_out = chain[NB];

endmodule

// File: rtl/video_capture.sv
// Pixel-stream capture: frame geometry, linear capture-memory writes and
// a per-frame CRC-32, all qualified by the pixel clock enable CE.
module video_capture
   import scv_pkg::*;
#(
   parameter int DW    = 24,
   parameter int MAX_W = 512,
   parameter int MAX_H = 512,
   parameter int AW    = $clog2(MAX_W*MAX_H)
) (
   input  logic                       CLK,
   input  logic                       RES,
   input  logic                       CE,
   input  logic                       DE,
   input  logic                       HS,
   input  logic                       VS,
   input  logic [DW-1:0]              RGB,
   input  logic                       ARM,
   input  logic                       ABORT,
   input  logic [7:0]                 NFRAMES,
   output logic                       WR,
   output logic [AW-1:0]              WA,
   output logic [DW-1:0]              WD,
   output logic                       BUSY,
   output logic                       DONE,
   output logic [$clog2(MAX_W+1)-1:0] LINE_W,
   output logic [$clog2(MAX_H+1)-1:0] LINES,
   output logic [31:0]                CRC,
   output logic                       CRC_VALID,
   output logic                       ERR_LEN,
   output logic                       ERR_OVF
);

   localparam int          XW      = $clog2(MAX_W+1);
   localparam int          YW      = $clog2(MAX_H+1);
   localparam logic [AW:0] MAX_PIX = (AW+1)'(MAX_W*MAX_H);

   vcap_state_t   state, state_nx;
   logic          vs_q, de_q;
   logic          fb, le, pix;
   logic [XW-1:0] x, x_b, first_len, first_len_eff;
   logic [YW-1:0] y, y_b, y_le;
   logic [AW:0]   addr, addr_b;
   logic [31:0]   crc_r, crc_b, crc_nx;
   logic [7:0]    frame_cnt, nf_target;
   logic          last_frame, start, cap_pix, len_err;
   logic          unused_hs;

   assign unused_hs = HS;
   assign BUSY      = (state != VCAP_IDLE);

   // The *_b values are the counters a pixel on this sample sees: a pixel on
   // the boundary sample belongs to the freshly initialised frame.
   always_comb begin
      fb            = CE & VS & ~vs_q;
      le            = CE & ~DE & de_q;
      pix           = CE & DE;
      nf_target     = (NFRAMES == 8'd0) ? 8'd1 : NFRAMES;
      last_frame    = ((frame_cnt + 8'd1) == nf_target);
      start         = ~ABORT & fb & ((state == VCAP_WAIT_VS) | ((state == VCAP_CAPTURE) & ~last_frame));
      cap_pix       = ~ABORT & pix & (start | ((state == VCAP_CAPTURE) & ~fb));
      x_b           = start ? '0 : x;
      y_b           = start ? '0 : y;
      addr_b        = start ? '0 : addr;
      crc_b         = start ? CRC32_INIT : crc_r;
      first_len_eff = (le && (y == '0)) ? x : first_len;
      len_err       = le && (y != '0) && (x != first_len);
      y_le          = (le && (y != YW'(MAX_H))) ? y + 1'b1 : y;
   end

   crc32_par #(.DW(DW)) u_crc (
      .crc_in (crc_b),
      .data   (RGB),
      .crc_out(crc_nx)
   );

   always_ff @(posedge CLK) begin
      if (RES) state <= VCAP_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         VCAP_IDLE:    if (ARM) state_nx = VCAP_WAIT_VS;
         VCAP_WAIT_VS: if (fb) state_nx = VCAP_CAPTURE;
         VCAP_CAPTURE: if (fb && last_frame) state_nx = VCAP_IDLE;
         default:      state_nx = VCAP_IDLE;
      endcase
      if (ABORT) state_nx = VCAP_IDLE;
   end

   always_ff @(posedge CLK) begin
      if (RES) begin
         vs_q      <= 1'b0;
         de_q      <= 1'b0;
         x         <= '0;
         y         <= '0;
         addr      <= '0;
         first_len <= '0;
         crc_r     <= '0;
         frame_cnt <= '0;
         WR        <= 1'b0;
         WA        <= '0;
         WD        <= '0;
         DONE      <= 1'b0;
         LINE_W    <= '0;
         LINES     <= '0;
         CRC       <= '0;
         CRC_VALID <= 1'b0;
         ERR_LEN   <= 1'b0;
         ERR_OVF   <= 1'b0;
      end else begin
         WR        <= 1'b0;
         CRC_VALID <= 1'b0;
         if (CE) begin
            vs_q <= VS;
            de_q <= DE;
         end
         if (!ABORT && (state == VCAP_IDLE) && ARM) begin
            DONE      <= 1'b0;
            ERR_LEN   <= 1'b0;
            ERR_OVF   <= 1'b0;
            frame_cnt <= '0;
         end
         // A line end coinciding with the boundary still closes the old frame.
         if (!ABORT && (state == VCAP_CAPTURE) && fb) begin
            CRC       <= crc_r ^ CRC32_INIT;
            LINES     <= y_le;
            LINE_W    <= first_len_eff;
            CRC_VALID <= 1'b1;
            frame_cnt <= frame_cnt + 8'd1;
            if (len_err)    ERR_LEN <= 1'b1;
            if (last_frame) DONE    <= 1'b1;
         end
         if (start) begin
            x         <= '0;
            y         <= '0;
            addr      <= '0;
            first_len <= '0;
            crc_r     <= CRC32_INIT;
         end
         if (!ABORT && (state == VCAP_CAPTURE) && !fb && le) begin
            if (y == '0) first_len <= x;
            if (len_err) ERR_LEN <= 1'b1;
            x <= '0;
            y <= y_le;
         end
         // Overflowed pixels still feed the CRC; only the write is dropped.
         if (cap_pix) begin
            crc_r <= crc_nx;
            if (x_b != XW'(MAX_W)) x <= x_b + 1'b1;
            if ((addr_b == MAX_PIX) || (y_b == YW'(MAX_H))) begin
               ERR_OVF <= 1'b1;
            end else begin
               WR   <= 1'b1;
               WA   <= addr_b[AW-1:0];
               WD   <= RGB;
               addr <= addr_b + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_video_capture.sv
// Directed bench for video_capture: three instances (8-bit, 24-bit, tiny overflow
// geometry) share one timing generator; only the armed instance captures.
module tb_video_capture;

   logic        clk = 1'b0;
   logic        RES, CE, DE, HS, VS;
   logic [23:0] RGB;
   logic [2:0]  arm, abort;
   logic [7:0]  nframes;

   logic [2:0]  wr, busy, done, crcv, errl, erro;
   logic [17:0] wa0, wa1;
   logic [2:0]  wa2;
   logic [7:0]  wd0, wd2;
   logic [23:0] wd1;
   logic [9:0]  lw0, lw1, ln0, ln1;
   logic [2:0]  lw2;
   logic [1:0]  ln2;
   logic [31:0] crc0, crc1, crc2;

   always #5 clk = ~clk;

   video_capture #(.DW(8)) u0 (
      .CLK(clk), .RES(RES), .CE(CE), .DE(DE), .HS(HS), .VS(VS), .RGB(RGB[7:0]),
      .ARM(arm[0]), .ABORT(abort[0]), .NFRAMES(nframes), .WR(wr[0]), .WA(wa0), .WD(wd0),
      .BUSY(busy[0]), .DONE(done[0]), .LINE_W(lw0), .LINES(ln0), .CRC(crc0),
      .CRC_VALID(crcv[0]), .ERR_LEN(errl[0]), .ERR_OVF(erro[0]));

   video_capture #(.DW(24)) u1 (
      .CLK(clk), .RES(RES), .CE(CE), .DE(DE), .HS(HS), .VS(VS), .RGB(RGB),
      .ARM(arm[1]), .ABORT(abort[1]), .NFRAMES(nframes), .WR(wr[1]), .WA(wa1), .WD(wd1),
      .BUSY(busy[1]), .DONE(done[1]), .LINE_W(lw1), .LINES(ln1), .CRC(crc1),
      .CRC_VALID(crcv[1]), .ERR_LEN(errl[1]), .ERR_OVF(erro[1]));

   video_capture #(.DW(8), .MAX_W(4), .MAX_H(2)) u2 (
      .CLK(clk), .RES(RES), .CE(CE), .DE(DE), .HS(HS), .VS(VS), .RGB(RGB[7:0]),
      .ARM(arm[2]), .ABORT(abort[2]), .NFRAMES(nframes), .WR(wr[2]), .WA(wa2), .WD(wd2),
      .BUSY(busy[2]), .DONE(done[2]), .LINE_W(lw2), .LINES(ln2), .CRC(crc2),
      .CRC_VALID(crcv[2]), .ERR_LEN(errl[2]), .ERR_OVF(erro[2]));

   typedef struct {int d; int wa; int wd;} wr_t;
   wr_t wq[$];
   int  vcnt[3];

   always @(negedge clk) begin
      if (wr[0]) wq.push_back('{0, int'(wa0), int'(wd0)});
      if (wr[1]) wq.push_back('{1, int'(wa1), int'(wd1)});
      if (wr[2]) wq.push_back('{2, int'(wa2), int'(wd2)});
      for (int i = 0; i < 3; i++) if (crcv[i]) vcnt[i]++;
   end

   typedef struct packed {
      logic [31:0] crc;
      logic [15:0] lines, lw;
      logic        busy, done, el, eo, wr, cv;
   } out_t;

   function automatic out_t snap(input int d);
      out_t o;
      case (d)
         0:       o = '{crc0, 16'(ln0), 16'(lw0), busy[0], done[0], errl[0], erro[0], wr[0], crcv[0]};
         1:       o = '{crc1, 16'(ln1), 16'(lw1), busy[1], done[1], errl[1], erro[1], wr[1], crcv[1]};
         default: o = '{crc2, 16'(ln2), 16'(lw2), busy[2], done[2], errl[2], erro[2], wr[2], crcv[2]};
      endcase
      return o;
   endfunction

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One CE sample, followed by a CE-low cycle carrying inverted junk.
   task automatic samp(input logic de, input logic vs, input logic [23:0] rgb);
      DE = de; VS = vs; RGB = rgb; HS = ~de; CE = 1'b1;
      @(posedge clk); #1;
      CE = 1'b0; DE = ~de; VS = ~vs; RGB = ~rgb;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) samp(1'b0, 1'b0, 24'h0);
   endtask

   task automatic vs_pulse();
      samp(1'b0, 1'b1, 24'h0);
      idle(2);
   endtask

   task automatic line(input int n, input int base);
      for (int i = 0; i < n; i++) samp(1'b1, 1'b0, 24'(base + i));
      idle(2);
   endtask

   task automatic pulse(input logic [2:0] a, input logic [2:0] b);
      arm = a; abort = b;
      @(posedge clk); #1;
      arm = '0; abort = '0;
   endtask

   // Reference CRC-32 over the pixel stream, bit-serial, bytes MSB first.
   function automatic logic [31:0] ref_crc(input int nb, input int npix, input int base);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      for (int p = 0; p < npix; p++)
         for (int b = nb - 1; b >= 0; b--) begin
            c = c ^ 32'(((base + p) >> (8 * b)) & 255);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
         end
      return ~c;
   endfunction

   typedef struct {
      string       name;
      int          d, nf, nl, l0, l1, l2, base;
      logic [31:0] crc;
      int          lines, lw, el, eo, wpf;
   } vec_t;

   function automatic vec_t mk(input string name, input int d, input int nf, input int nl,
                               input int l0, input int l1, input int l2, input int base,
                               input int lines, input int lw, input int el, input int eo,
                               input int wpf);
      vec_t v;
      v.name = name; v.d = d; v.nf = nf; v.nl = nl; v.l0 = l0; v.l1 = l1; v.l2 = l2;
      v.base = base; v.lines = lines; v.lw = lw; v.el = el; v.eo = eo; v.wpf = wpf;
      v.crc  = ref_crc((d == 1) ? 3 : 1, l0 + l1 + l2, base);
      return v;
   endfunction

   function automatic int len_of(input vec_t v, input int i);
      return (i == 0) ? v.l0 : (i == 1) ? v.l1 : v.l2;
   endfunction

   vec_t vecs[5];

   initial begin
      vec_t  v;
      out_t  o;
      int    w0, c0, nfr, nw, off, lim;

      RES = 1'b1; CE = 1'b0; DE = 1'b0; HS = 1'b0; VS = 1'b0; RGB = '0;
      arm = '0; abort = '0; nframes = 8'd1;
      vecs[0] = mk("crc_std",   0, 1, 3, 3, 3, 3, 'h31, 3, 3, 0, 0, 9);
      vecs[1] = mk("multi",     1, 2, 2, 4, 4, 0, 0,    2, 4, 0, 0, 8);
      vecs[2] = mk("len_err",   0, 1, 3, 4, 4, 3, 0,    3, 4, 1, 0, 11);
      vecs[3] = mk("overflow",  2, 1, 3, 4, 4, 4, 'h10, -1, 4, 0, 1, 8);
      vecs[4] = mk("nframes0",  0, 0, 2, 2, 2, 0, 'hA0, 2, 2, 0, 0, 4);
      vecs[0].crc = 32'hCBF43926;

      repeat (3) @(posedge clk);
      #1 RES = 1'b0;
      for (int d = 0; d < 3; d++) begin
         o = snap(d);
         chk($sformatf("rst%0d_busy", d), 32'(o.busy), 0);
         chk($sformatf("rst%0d_done", d), 32'(o.done), 0);
         chk($sformatf("rst%0d_crc", d), o.crc, 0);
         chk($sformatf("rst%0d_err", d), {o.el, o.eo, o.wr, o.cv}, 0);
      end

      for (int t = 0; t < 5; t++) begin
         v = vecs[t];
         w0 = wq.size(); c0 = vcnt[v.d];
         nfr = (v.nf == 0) ? 1 : v.nf;
         nframes = 8'(v.nf);
         pulse(3'(1 << v.d), 3'b000);
         chk({v.name, "_busy_armed"}, 32'(snap(v.d).busy), 1);
         idle(2);
         vs_pulse();
         for (int f = 0; f < nfr; f++) begin
            off = 0;
            for (int l = 0; l < v.nl; l++) begin
               line(len_of(v, l), v.base + off);
               off += len_of(v, l);
            end
            vs_pulse();
         end
         o = snap(v.d);
         chk({v.name, "_crc"}, o.crc, v.crc);
         if (v.lines >= 0) chk({v.name, "_lines"}, 32'(o.lines), v.lines);
         chk({v.name, "_line_w"}, 32'(o.lw), v.lw);
         chk({v.name, "_err_len"}, 32'(o.el), v.el);
         chk({v.name, "_err_ovf"}, 32'(o.eo), v.eo);
         chk({v.name, "_done"}, 32'(o.done), 1);
         chk({v.name, "_busy"}, 32'(o.busy), 0);
         chk({v.name, "_crc_valid_cnt"}, vcnt[v.d] - c0, nfr);
         nw = wq.size() - w0;
         chk({v.name, "_writes"}, nw, nfr * v.wpf);
         lim = (nw < nfr * v.wpf) ? nw : nfr * v.wpf;
         for (int i = 0; i < lim; i++) begin
            chk($sformatf("%s_wa%0d", v.name, i), wq[w0+i].wa, i % v.wpf);
            chk($sformatf("%s_wd%0d", v.name, i), wq[w0+i].wd,
                (v.base + i % v.wpf) & ((v.d == 1) ? 'hFFFFFF : 'hFF));
         end
      end

      // ARM while capturing must not restart the capture.
      nframes = 8'd1; c0 = vcnt[1];
      pulse(3'b010, 3'b000);
      idle(1);
      vs_pulse();
      line(2, 5);
      pulse(3'b010, 3'b000);
      line(2, 7);
      vs_pulse();
      o = snap(1);
      chk("armbusy_done", 32'(o.done), 1);
      chk("armbusy_busy", 32'(o.busy), 0);
      chk("armbusy_lines", 32'(o.lines), 2);
      chk("armbusy_valid_cnt", vcnt[1] - c0, 1);
      chk("armbusy_crc", o.crc, ref_crc(3, 4, 5));

      pulse(3'b010, 3'b000);
      chk("rearm_done_clr", 32'(snap(1).done), 0);
      chk("rearm_busy", 32'(snap(1).busy), 1);
      pulse(3'b010, 3'b010);
      chk("abort_arm_busy", 32'(snap(1).busy), 0);
      pulse(3'b100, 3'b100);
      chk("abort_arm_idle", 32'(snap(2).busy), 0);

      // ABORT mid-frame: back to IDLE, no result published.
      c0 = vcnt[1];
      pulse(3'b010, 3'b000);
      idle(1);
      vs_pulse();
      samp(1'b1, 1'b0, 24'h1); samp(1'b1, 1'b0, 24'h2);
      pulse(3'b000, 3'b010);
      chk("abort_busy", 32'(snap(1).busy), 0);
      idle(2);
      vs_pulse();
      chk("abort_done", 32'(snap(1).done), 0);
      chk("abort_no_valid", vcnt[1] - c0, 0);

      // RES mid-frame: everything back to zero, no CRC_VALID.
      c0 = vcnt[1];
      pulse(3'b010, 3'b000);
      idle(1);
      vs_pulse();
      samp(1'b1, 1'b0, 24'h3);
      RES = 1'b1;
      @(posedge clk); #1;
      RES = 1'b0;
      o = snap(1);
      chk("res_busy", 32'(o.busy), 0);
      chk("res_crc", o.crc, 0);
      chk("res_geom", {o.lines, o.lw}, 0);
      chk("res_flags", {o.done, o.el, o.eo, o.wr, o.cv}, 0);
      chk("res_crc0", snap(0).crc, 0);
      idle(1);
      vs_pulse();
      chk("res_no_valid", vcnt[1] - c0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
